// File: rtl/elevator_pkg.sv
// ----------------------------------------------------------------
// elevator_pkg: shared state, direction and command encodings
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // {motor, direction} as driven by the controller
  localparam logic [1:0] CMD_STOP       = 2'b00;
  localparam logic [1:0] CMD_UP_GOING   = {1'b1, DIR_UP};
  localparam logic [1:0] CMD_DOWN_GOING = {1'b1, DIR_DOWN};

  function automatic logic at_limit(input int floor, input logic dir, input int num_floors);
    return (dir == DIR_UP) ? (floor == num_floors - 1) : (floor == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/elevator_door_timer.sv
// ----------------------------------------------------------------
// elevator_door_timer: reloadable door dwell countdown with done flag
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module elevator_door_timer #(
  parameter int DOOR_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic dec_i,
  output logic done_o
);

  localparam int               CNT_W    = $clog2(DOOR_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DOOR_CYCLES - 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= LOAD_VAL;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign done_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/elevator_floor_tracker.sv
// ----------------------------------------------------------------
// elevator_floor_tracker: car position, motor drive and door dwell
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module elevator_floor_tracker #(
  parameter int NUM_FLOORS      = 5,
  parameter int FLOOR_W         = 5,
  parameter int TICKS_PER_FLOOR = 16,
  parameter int DOOR_CYCLES     = 32,
  parameter int RESET_FLOOR     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               motor_i,
  input  logic               direction_i,
  input  logic               door_hold_i,
  output logic [FLOOR_W-1:0] floor_cur_o,
  output logic               at_floor_o,
  output logic               motor_drive_o,
  output logic               dir_drive_o,
  output logic               door_open_o,
  output logic               arrived_o,
  output logic               limit_err_o
);

  import elevator_pkg::*;

  localparam int                 OFF_W     = $clog2(TICKS_PER_FLOOR);
  localparam logic [OFF_W-1:0]   LAST_TICK = OFF_W'(TICKS_PER_FLOOR - 1);
  localparam logic [FLOOR_W-1:0] RST_FLOOR = FLOOR_W'(RESET_FLOOR);

  state_e             state_q;
  logic [OFF_W-1:0]   offset_q;
  logic               dir_q;
  logic [FLOOR_W-1:0] floor_q;
  logic [FLOOR_W-1:0] floor_d;
  logic               at_floor_q;
  logic               motor_drive_q;
  logic               dir_drive_q;
  logic               door_open_q;
  logic               arrived_q;
  logic               limit_err_q;

  logic seg_end;
  logic req_same_dir;
  logic limit_hit;
  logic keep_moving;
  logic timer_load;
  logic timer_dec;
  logic timer_done;

  // Arrival decision uses the inputs of the last tick of the segment, so a
  // continuing car keeps a strict TICKS_PER_FLOOR cadence between floors.
  always_comb begin
    seg_end      = (state_q == MOVE) && (offset_q == LAST_TICK);
    floor_d      = (dir_q == DIR_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
    req_same_dir = motor_i && (direction_i == dir_q);
    limit_hit    = req_same_dir && at_limit(int'(floor_d), dir_q, NUM_FLOORS);
    keep_moving  = req_same_dir && !limit_hit;
    timer_load   = (seg_end && !keep_moving) || ((state_q == DOOR) && door_hold_i);
    timer_dec    = (state_q == DOOR) && !door_hold_i;
  end

  elevator_door_timer #(
    .DOOR_CYCLES(DOOR_CYCLES)
  ) u_door_timer (
    .clk   (clk),
    .rst   (rst),
    .load_i(timer_load),
    .dec_i (timer_dec),
    .done_o(timer_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      offset_q      <= '0;
      dir_q         <= DIR_DOWN;
      floor_q       <= RST_FLOOR;
      at_floor_q    <= 1'b1;
      motor_drive_q <= 1'b0;
      dir_drive_q   <= 1'b0;
      door_open_q   <= 1'b0;
      arrived_q     <= 1'b0;
      limit_err_q   <= 1'b0;
    end else begin
      arrived_q   <= 1'b0;
      limit_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (motor_i) begin
            if (at_limit(int'(floor_q), direction_i, NUM_FLOORS)) begin
              limit_err_q <= 1'b1;
            end else begin
              state_q       <= MOVE;
              dir_q         <= direction_i;
              offset_q      <= '0;
              motor_drive_q <= 1'b1;
              dir_drive_q   <= direction_i;
              at_floor_q    <= 1'b0;
            end
          end
        end
        MOVE: begin
          if (seg_end) begin
            floor_q    <= floor_d;
            offset_q   <= '0;
            at_floor_q <= 1'b1;
            arrived_q  <= 1'b1;
            if (!keep_moving) begin
              state_q       <= DOOR;
              motor_drive_q <= 1'b0;
              door_open_q   <= 1'b1;
              limit_err_q   <= limit_hit;
            end
          end else begin
            offset_q   <= offset_q + OFF_W'(1);
            at_floor_q <= 1'b0;
          end
        end
        DOOR: begin
          if (!door_hold_i && timer_done) begin
            door_open_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign floor_cur_o   = floor_q;
  assign at_floor_o    = at_floor_q;
  assign motor_drive_o = motor_drive_q;
  assign dir_drive_o   = dir_drive_q;
  assign door_open_o   = door_open_q;
  assign arrived_o     = arrived_q;
  assign limit_err_o   = limit_err_q;

endmodule

`default_nettype wire

// File: tb/tb_elevator_floor_tracker.sv
// ----------------------------------------------------------------
// tb_elevator_floor_tracker: directed and random checks against a tick-position model
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module tb_elevator_floor_tracker;

  localparam int NF = 5;
  localparam int FW = 5;
  localparam int T  = 4;
  localparam int DC = 3;
  localparam int RF = 0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          motor = 1'b0;
  logic          direction = 1'b0;
  logic          door_hold = 1'b0;
  logic [FW-1:0] floor_cur;
  logic          at_floor;
  logic          motor_drive;
  logic          dir_drive;
  logic          door_open;
  logic          arrived;
  logic          limit_err;

  int errors = 0;
  int checks = 0;

  // Model: car position in ticks, remaining open-door cycles, motion flag.
  int pos       = RF * T;
  int m_floor   = RF;
  int door_left = 0;
  bit moving    = 1'b0;
  bit mdir      = 1'b0;
  bit e_at      = 1'b1;
  bit e_arr     = 1'b0;
  bit e_lim     = 1'b0;
  int n_arr     = 0;

  always #5 clk = ~clk;

  elevator_floor_tracker #(
    .NUM_FLOORS     (NF),
    .FLOOR_W        (FW),
    .TICKS_PER_FLOOR(T),
    .DOOR_CYCLES    (DC),
    .RESET_FLOOR    (RF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .motor_i      (motor),
    .direction_i  (direction),
    .door_hold_i  (door_hold),
    .floor_cur_o  (floor_cur),
    .at_floor_o   (at_floor),
    .motor_drive_o(motor_drive),
    .dir_drive_o  (dir_drive),
    .door_open_o  (door_open),
    .arrived_o    (arrived),
    .limit_err_o  (limit_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit m, input bit d, input bit h);
    e_arr = 1'b0;
    e_lim = 1'b0;
    if (r) begin
      pos = RF * T; m_floor = RF; moving = 1'b0; door_left = 0; mdir = 1'b0; e_at = 1'b1;
    end else if (door_left > 0) begin
      door_left = h ? DC : door_left - 1;
    end else if (moving) begin
      pos = mdir ? pos + 1 : pos - 1;
      if (pos % T == 0) begin
        m_floor = pos / T;
        e_arr   = 1'b1;
        e_at    = 1'b1;
        if (m && d == mdir && (mdir ? (m_floor == NF - 1) : (m_floor == 0))) begin
          e_lim = 1'b1; moving = 1'b0; door_left = DC;
        end else if (!(m && d == mdir)) begin
          moving = 1'b0; door_left = DC;
        end
      end else begin
        e_at = 1'b0;
      end
    end else if (m) begin
      if (d ? (m_floor == NF - 1) : (m_floor == 0)) e_lim = 1'b1;
      else begin moving = 1'b1; mdir = d; e_at = 1'b0; end
    end
  endtask

  task automatic step(input bit r, input bit m, input bit d, input bit h);
    rst = r; motor = m; direction = d; door_hold = h;
    @(posedge clk);
    model_edge(r, m, d, h);
    @(negedge clk);
    if (arrived) n_arr++;
    check("floor_cur",   32'(floor_cur),   32'(m_floor));
    check("at_floor",    32'(at_floor),    32'(e_at));
    check("motor_drive", 32'(motor_drive), 32'(moving));
    check("dir_drive",   32'(dir_drive),   32'(mdir));
    check("door_open",   32'(door_open),   32'(door_left > 0));
    check("arrived",     32'(arrived),     32'(e_arr));
    check("limit_err",   32'(limit_err),   32'(e_lim));
  endtask

  task automatic run(input int n, input bit r, input bit m, input bit d, input bit h);
    for (int i = 0; i < n; i++) step(r, m, d, h);
  endtask

  initial begin
    // Reset values
    run(2, 1, 0, 0, 0);
    check("rst_floor", 32'(floor_cur), 32'(RF));
    check("rst_at_floor", 32'(at_floor), 32'd1);

    // Single floor move with door dwell
    step(0, 1, 1, 0);
    run(3, 0, 0, 0, 0);
    check("t1_drive_before_arrival", 32'(motor_drive), 32'd1);
    step(0, 0, 0, 0);
    check("t1_arrived", 32'(arrived), 32'd1);
    check("t1_floor", 32'(floor_cur), 32'd1);
    run(3, 0, 0, 0, 0);
    check("t1_door_closed", 32'(door_open), 32'd0);
    check("t1_idle_at_floor", 32'(at_floor), 32'd1);
    run(2, 0, 0, 0, 0);

    // Continuous climb to the top with limit on arrival
    run(1, 1, 0, 0, 0);
    n_arr = 0;
    run(17, 0, 1, 1, 0);
    check("t2_arrivals", 32'(n_arr), 32'd4);
    check("t2_floor", 32'(floor_cur), 32'd4);
    check("t2_limit", 32'(limit_err), 32'd1);
    check("t2_door", 32'(door_open), 32'd1);
    check("t2_drive", 32'(motor_drive), 32'd0);
    run(4, 0, 0, 0, 0);

    // Refused move below floor 0
    run(1, 1, 0, 0, 0);
    step(0, 1, 0, 0);
    check("t3_limit", 32'(limit_err), 32'd1);
    check("t3_drive", 32'(motor_drive), 32'd0);
    step(0, 0, 0, 0);
    check("t3_no_door", 32'(door_open), 32'd0);

    // Direction flip mid-segment, then door hold with a pending down request
    run(1, 1, 0, 0, 0);
    run(10, 0, 1, 1, 0);
    run(2, 0, 1, 0, 0);
    check("t4_still_moving", 32'(motor_drive), 32'd1);
    step(0, 1, 0, 0);
    check("t4_floor", 32'(floor_cur), 32'd3);
    check("t4_door", 32'(door_open), 32'd1);
    run(10, 0, 1, 0, 1);
    check("t5_door_held", 32'(door_open), 32'd1);
    check("t5_no_motion", 32'(motor_drive), 32'd0);
    run(2, 0, 1, 0, 0);
    check("t5_door_still_open", 32'(door_open), 32'd1);
    step(0, 1, 0, 0);
    check("t5_door_closed", 32'(door_open), 32'd0);
    step(0, 1, 0, 0);
    check("t4_down_start", 32'(motor_drive), 32'd1);
    check("t4_down_dir", 32'(dir_drive), 32'd0);
    run(8, 0, 0, 0, 0);
    check("t4_floor2", 32'(floor_cur), 32'd2);

    // Reset mid-move from floor 3
    run(1, 1, 0, 0, 0);
    run(15, 0, 1, 1, 0);
    step(1, 1, 1, 0);
    check("t6_floor", 32'(floor_cur), 32'd0);
    check("t6_drive", 32'(motor_drive), 32'd0);
    check("t6_door", 32'(door_open), 32'd0);
    check("t6_at_floor", 32'(at_floor), 32'd1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
